dac_pattern_player: RTL and testbench
=====================================

# dac_pattern_player

Buffered DAC waveform source that drives one `dacX_data` input of the ADC/DAC monitor stage. The host loads a pattern of `NUMBER_OF_LINE` 16-bit samples per word into an internal block RAM. On `start`, the block streams the pattern one word per clock, either once or looping seamlessly. One instance sits upstream of each DAC channel; the monitor stage registers its output onto the DAC AXI-Stream.

## Interface
- `NUMBER_OF_LINE`, 8: 16-bit sample lanes per word; lane i is bits [16*i+15:16*i].
- `ADDR_WIDTH`, 10: pattern RAM address width; depth = 2^ADDR_WIDTH words.
- `clock`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  pattern RAM write strobe.
- `wr_addr`  in  ADDR_WIDTH  pattern RAM write address.
- `wr_data`  in  16*NUMBER_OF_LINE  pattern RAM write word.
- `start`  in  1  level, sampled each edge; begins playback when idle.
- `stop`  in  1  level, sampled each edge; aborts playback.
- `play_length`  in  ADDR_WIDTH+1  words to play (addresses 0..play_length-1); sampled on accepted start.
- `loop_enable`  in  1  1 = repeat pattern indefinitely; sampled on accepted start.
- `dac_data`  out  16*NUMBER_OF_LINE  registered sample word; goes to the monitor's `dacX_data`.
- `dac_data_valid`  out  1  high when `dac_data` carries a pattern word.
- `busy`  out  1  high while playback is active.
- `done`  out  1  one-cycle pulse when a non-looping playback completes.
- `loop_count`  out  16  completed passes in the current playback; saturates at 16'hFFFF.

## Operation
- RAM: simple dual-port, one write port and one read port, both on `clock`.
  - Read latency is 1 cycle.
  - Read-first: a write and a read to the same address on the same edge returns the old data.
  - Writes are accepted in any state, including during playback.
- States: IDLE and PLAY. Pipeline: address stage, then RAM read stage, then output register.
- IDLE → PLAY: `start`=1, `stop`=0, and the effective length is non-zero.
  - Effective length = min(`play_length`, 2^ADDR_WIDTH).
  - Latches the effective length and `loop_enable`.
  - Sets read address to 0 and clears `loop_count` to 0.
- `start` with `play_length`=0 is ignored: state stays IDLE, no `done`.
- PLAY: the read address increments by 1 every cycle.
  - At address length-1 with loop latched: the next address is 0 with no gap cycle, and `loop_count` increments (saturating).
  - At address length-1 without loop: address issue stops, state → IDLE, `loop_count` increments once, and `done` is pulsed when that last word leaves the output register.
- `stop`=1 in PLAY: state → IDLE at that edge.
  - In-flight reads are discarded.
  - No `done` pulse; `loop_count` holds its value.
- `start` while in PLAY is ignored. If `start` and `stop` are sampled on the same edge, `stop` wins in any state.
- When no pattern word is being output: `dac_data` = 0 (mid-scale, two's complement) and `dac_data_valid` = 0.
- Length 1 without loop: exactly one word is output. Length 1 with loop: word 0 repeats every cycle and `loop_count` increments every cycle.

## Timing
- Reset (synchronous, active-high): all outputs go to 0 at the first edge with `reset`=1.
  - Affects `dac_data`, `dac_data_valid`, `busy`, `done` and `loop_count`.
  - State → IDLE; pipeline valid bits are cleared.
  - RAM contents are not cleared.
  - Reset mid-playback behaves like `stop` and also clears `loop_count`.
- Accepted `start` sampled at edge k:
  - `busy`=1 after edge k.
  - Word 0 is on `dac_data` with `dac_data_valid`=1 after edge k+2.
  - Word n appears after edge k+2+n.
- Non-looping playback of length L started at edge k:
  - Last word is on `dac_data` after edge k+L+1.
  - After edge k+L+2: `done`=1 for exactly one cycle, `dac_data_valid`=0, `dac_data`=0, `busy`=0.
  - A new `start` is accepted from the edge at which `busy` is sampled 0.
- `stop` sampled at edge s: `busy`=0 after edge s. `dac_data_valid`=0 and `dac_data`=0 after edge s+1. The word already in the output register remains for that one cycle only.
- Loop wrap: `loop_count` updates on the edge that issues the wrap address. In the output stream, the last word is followed directly by word 0.
- Throughput: one word per clock with no bubbles. No backpressure: the downstream DAC stream is always ready.

## Test plan
- Reset, then write words 0..3 with lane i = addr*16+i. Start with length 4, no loop → words 0,1,2,3 appear on edges k+2..k+5, then `done`=1 for exactly one cycle at k+6, then `busy`=0 and `dac_data`=0.
- Same pattern with `loop_enable`=1, run 10 cycles after the first word → sequence 0,1,2,3,0,1,2,3,0,1 with no gaps, `loop_count`=2, `busy` held at 1.
- Looping playback, assert `stop` at edge s → `busy`=0 after edge s, `dac_data_valid`=0 after edge s+1, no `done` pulse, `loop_count` unchanged.
- Start with `play_length`=0 → no state change, no `done`, outputs stay 0. Start with `play_length`=2^ADDR_WIDTH+1 → exactly 2^ADDR_WIDTH words played.
- `start` and `stop` high on the same edge while IDLE → `busy` remains 0. `start` pulsed again mid-playback → no restart, sequence continues unchanged.
- During looping playback, write address 2 with a new value → the old value plays if the write coincides with the read of address 2; the new value plays on the next pass.
- Assert `reset` mid-playback → all outputs are 0 after that edge. The next `start` replays the pattern from word 0, confirming RAM contents were retained.

Source files
------------

// File: rtl/dac_pattern_player_if.sv
// Host-side bundle of the pattern player: RAM write port, playback control
// and the DAC sample stream with its status outputs.
interface dac_pattern_player_if #(
  parameter int NUMBER_OF_LINE = 8,
  parameter int ADDR_WIDTH     = 10
);
  logic                          wr_en;
  logic [ADDR_WIDTH-1:0]         wr_addr;
  logic [16*NUMBER_OF_LINE-1:0]  wr_data;
  logic                          start;
  logic                          stop;
  logic [ADDR_WIDTH:0]           play_length;
  logic                          loop_enable;
  logic [16*NUMBER_OF_LINE-1:0]  dac_data;
  logic                          dac_data_valid;
  logic                          busy;
  logic                          done;
  logic [15:0]                   loop_count;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, play_length, loop_enable,
    input  dac_data, dac_data_valid, busy, done, loop_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, play_length, loop_enable,
    output dac_data, dac_data_valid, busy, done, loop_count
  );
endinterface

// File: rtl/dac_pattern_player.sv
// Block-RAM backed DAC waveform source: streams a host-loaded pattern one word
// per clock, once or looping, through an address / RAM-read / output pipeline.
module dac_pattern_player #(
  parameter int NUMBER_OF_LINE = 8,
  parameter int ADDR_WIDTH     = 10
) (
  input  logic                clock,
  input  logic                reset,
  dac_pattern_player_if.slave bus
);

  localparam int DATA_WIDTH = 16 * NUMBER_OF_LINE;
  localparam int LEN_WIDTH  = ADDR_WIDTH + 1;
  localparam logic [LEN_WIDTH-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  // DRAIN keeps busy high while the last non-looping word leaves the pipeline.
  typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;

  logic [DATA_WIDTH-1:0] pattern_ram [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] ram_q_reg;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [LEN_WIDTH-1:0]  len_reg, len_next;
  logic                  loop_reg, loop_next;
  logic [15:0]           count_reg, count_next;

  logic                  rd_valid_reg;
  logic                  rd_last_reg;
  logic                  out_valid_reg;
  logic                  out_last_reg;
  logic                  done_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [DATA_WIDTH-1:0] out_data_next;

  logic [LEN_WIDTH-1:0]  eff_len;
  logic                  accept;
  logic                  issuing;
  logic                  at_last;
  logic                  hold_out;
  logic [15:0]           count_inc;

  assign eff_len   = (bus.play_length > DEPTH) ? DEPTH : bus.play_length;
  assign accept    = (state_reg == IDLE) && bus.start && !bus.stop && (eff_len != '0);
  assign issuing   = (state_reg == PLAY);
  assign at_last   = ({1'b0, addr_reg} == (len_reg - LEN_WIDTH'(1)));
  assign count_inc = (count_reg == 16'hFFFF) ? count_reg : count_reg + 16'd1;
  // A stop freezes the word already on the output for one more cycle.
  assign hold_out  = bus.stop && (state_reg != IDLE);

  // Read-first simple dual-port RAM; contents survive reset.
  always_ff @(posedge clock) begin
    if (bus.wr_en) begin
      pattern_ram[bus.wr_addr] <= bus.wr_data;
    end
    ram_q_reg <= pattern_ram[addr_reg];
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    len_next   = len_reg;
    loop_next  = loop_reg;
    count_next = count_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = PLAY;
          addr_next  = '0;
          len_next   = eff_len;
          loop_next  = bus.loop_enable;
          count_next = 16'd0;
        end
      end
      PLAY: begin
        if (at_last) begin
          addr_next  = '0;
          count_next = count_inc;
          if (!loop_reg) begin
            state_next = DRAIN;
          end
        end else begin
          addr_next = addr_reg + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (out_valid_reg && out_last_reg) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (bus.stop) begin
      state_next = IDLE;
      count_next = count_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUMBER_OF_LINE; gi++) begin : g_lane
      assign out_data_next[16*gi +: 16] = rd_valid_reg ? ram_q_reg[16*gi +: 16] : 16'h0000;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      len_reg       <= '0;
      loop_reg      <= 1'b0;
      count_reg     <= 16'd0;
      rd_valid_reg  <= 1'b0;
      rd_last_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      len_reg      <= len_next;
      loop_reg     <= loop_next;
      count_reg    <= count_next;
      rd_valid_reg <= issuing && !bus.stop;
      rd_last_reg  <= issuing && at_last && !loop_reg && !bus.stop;
      if (hold_out) begin
        out_last_reg <= 1'b0;
      end else begin
        out_valid_reg <= rd_valid_reg;
        out_last_reg  <= rd_last_reg;
        out_data_reg  <= out_data_next;
      end
      done_reg <= out_valid_reg && out_last_reg && !bus.stop;
    end
  end

  assign bus.dac_data       = out_data_reg;
  assign bus.dac_data_valid = out_valid_reg;
  assign bus.busy           = (state_reg != IDLE);
  assign bus.done           = done_reg;
  assign bus.loop_count     = count_reg;

endmodule

// File: tb/tb_dac_pattern_player.sv
// Randomized scoreboard bench for dac_pattern_player: a cycle-indexed model of
// the pattern stream feeds an expected-word queue checked by a negedge monitor.
module tb_dac_pattern_player;

  localparam int NL    = 8;
  localparam int AW    = 10;
  localparam int DW    = 16 * NL;
  localparam int DEPTH = 1 << AW;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dac_pattern_player_if #(.NUMBER_OF_LINE(NL), .ADDR_WIDTH(AW)) bus ();

  dac_pattern_player #(.NUMBER_OF_LINE(NL), .ADDR_WIDTH(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } sb_t;

  sb_t           sb[$];
  logic [DW-1:0] shown[int];
  logic [DW-1:0] mem_m [DEPTH];

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 0;

  // Reference model state: playback described by its start edge and length.
  bit   active = 0;
  int   k_edge = 0;
  int   len_m = 0;
  bit   loop_m = 0;
  bit   exp_busy = 0;
  bit   exp_done = 0;
  int   exp_count = 0;

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  function automatic void push_word(int due, logic [DW-1:0] d);
    sb_t s;
    s.due  = due;
    s.data = d;
    sb.push_back(s);
    shown[due] = d;
  endfunction

  // Evaluated once per clock edge with the inputs that edge sampled.
  task automatic model_edge();
    int e;
    int n;
    e = cyc;
    exp_done = 0;
    if (reset) begin
      sb.delete();
      active    = 0;
      exp_busy  = 0;
      exp_count = 0;
    end else if (active && bus.stop) begin
      sb.delete();
      if (shown.exists(e - 1)) push_word(e, shown[e - 1]);
      active   = 0;
      exp_busy = 0;
    end else if (active) begin
      n = e - k_edge - 1;
      if (n >= 0 && (loop_m || n < len_m)) push_word(e + 1, mem_m[n % len_m]);
      if (loop_m) begin
        exp_count = ((e - k_edge) / len_m > 65535) ? 65535 : (e - k_edge) / len_m;
      end else begin
        if (e - k_edge >= len_m) exp_count = 1;
        if (e == k_edge + len_m + 2) begin
          active   = 0;
          exp_busy = 0;
          exp_done = 1;
        end
      end
    end else if (bus.start && !bus.stop && bus.play_length != 0) begin
      active    = 1;
      k_edge    = e;
      len_m     = (int'(bus.play_length) > DEPTH) ? DEPTH : int'(bus.play_length);
      loop_m    = bus.loop_enable;
      exp_count = 0;
      exp_busy  = 1;
    end
    if (bus.wr_en) mem_m[bus.wr_addr] = bus.wr_data;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    model_edge();
  endtask

  task automatic run(int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic start_play(int plen, bit lp);
    bus.play_length = (AW + 1)'(plen);
    bus.loop_enable = lp;
    bus.start = 1;
    tick();
    bus.start = 0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1;
    tick();
    bus.stop = 0;
  endtask

  always @(negedge clock) begin
    sb_t s;
    if (mon_en) begin
      vectors++;
      if (bus.busy !== exp_busy) begin
        miscompares++;
        $display("FAIL busy cycle %0d: got %b expected %b", cyc, bus.busy, exp_busy);
      end
      if (bus.done !== exp_done) begin
        miscompares++;
        $display("FAIL done cycle %0d: got %b expected %b", cyc, bus.done, exp_done);
      end
      if (bus.loop_count !== 16'(exp_count)) begin
        miscompares++;
        $display("FAIL loop_count cycle %0d: got %0d expected %0d", cyc, bus.loop_count, exp_count);
      end
      if (bus.dac_data_valid === 1'b1) begin
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_word cycle %0d: got %h expected no word", cyc, bus.dac_data);
        end else begin
          s = sb.pop_front();
          if (s.due != cyc || bus.dac_data !== s.data) begin
            miscompares++;
            $display("FAIL word cycle %0d: got %h expected %h due cycle %0d", cyc, bus.dac_data, s.data, s.due);
          end
        end
      end else begin
        if (bus.dac_data !== '0) begin
          miscompares++;
          $display("FAIL idle_data cycle %0d: got %h expected 0", cyc, bus.dac_data);
        end
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          s = sb.pop_front();
          miscompares++;
          $display("FAIL missing_word cycle %0d: got valid=%b expected %h", cyc, bus.dac_data_valid, s.data);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] w;
    int            plen;
    bit            lp;
    int            ncyc;
    int            stop_at;

    reset           = 1;
    bus.wr_en       = 0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.start       = 0;
    bus.stop        = 0;
    bus.play_length = '0;
    bus.loop_enable = 0;
    mon_en          = 1;
    tick();
    reset = 0;

    // Fill the whole RAM, then lay down the lane-indexed pattern at 0..3.
    bus.wr_en = 1;
    for (int a = 0; a < DEPTH; a++) begin
      bus.wr_addr = AW'(a);
      bus.wr_data = rand_word();
      tick();
    end
    for (int a = 0; a < 4; a++) begin
      for (int i = 0; i < NL; i++) w[16*i +: 16] = 16'(a * 16 + i);
      bus.wr_addr = AW'(a);
      bus.wr_data = w;
      tick();
    end
    bus.wr_en = 0;

    start_play(4, 0);
    run(8);

    start_play(4, 1);
    run(11);
    pulse_stop();
    run(3);

    start_play(0, 0);
    run(3);

    start_play(DEPTH + 1, 0);
    run(DEPTH + 4);

    bus.stop = 1;
    start_play(4, 0);
    bus.stop = 0;
    run(2);

    // Restart attempt and a pattern rewrite while looping.
    start_play(4, 1);
    run(5);
    bus.start = 1;
    tick();
    bus.start = 0;
    run(2);
    bus.wr_en   = 1;
    bus.wr_addr = AW'(2);
    bus.wr_data = rand_word();
    tick();
    bus.wr_en = 0;
    run(9);
    pulse_stop();
    run(2);

    start_play(4, 1);
    run(6);
    reset = 1;
    tick();
    reset = 0;
    run(2);
    start_play(4, 0);
    run(8);

    start_play(1, 0);
    run(5);
    start_play(1, 1);
    run(6);
    pulse_stop();
    run(2);

    for (int t = 0; t < 30; t++) begin
      plen    = $urandom_range(1, 8);
      lp      = $urandom_range(0, 1);
      ncyc    = $urandom_range(plen + 4, 3 * plen + 10);
      stop_at = ($urandom_range(0, 3) == 0 || lp) ? $urandom_range(1, ncyc) : ncyc + 1;
      start_play(plen, lp);
      for (int c = 1; c <= ncyc; c++) begin
        bus.wr_en   = ($urandom_range(0, 2) == 0);
        bus.wr_addr = AW'($urandom_range(0, 7));
        bus.wr_data = rand_word();
        bus.start   = ($urandom_range(0, 5) == 0);
        bus.stop    = (c == stop_at);
        tick();
      end
      bus.wr_en = 0;
      bus.start = 0;
      bus.stop  = 0;
      if (lp && stop_at > ncyc) pulse_stop();
      run(3);
    end

    run(2);
    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
